// File: rtl/rpm_control.sv
// Motor RPM setpoint combiner: dir_rpm minus signed alt_rpm, clamped to [0, RPM_MAX],
// then registered. Active-high asynchronous reset clears the setpoint.
module rpm_control #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] RPM_MAX = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] dir_rpm,
  input  logic [WIDTH-1:0] alt_rpm,
  output logic [WIDTH-1:0] rpm_set
);

  logic signed [WIDTH+1:0] raw;
  logic signed [WIDTH+1:0] max_ext;
  logic        [WIDTH-1:0] rpm_set_d;
  logic        [WIDTH-1:0] rpm_set_q;

  // Two guard bits: neither the subtraction nor the clamp comparison can overflow.
  always_comb begin
    max_ext   = $signed({2'b00, RPM_MAX});
    raw       = $signed({2'b00, dir_rpm}) - $signed({{2{alt_rpm[WIDTH-1]}}, alt_rpm});
    rpm_set_d = raw[WIDTH-1:0];
    if (raw[WIDTH+1]) begin
      rpm_set_d = '0;
    end else if (raw > max_ext) begin
      rpm_set_d = RPM_MAX;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      rpm_set_q <= '0;
    end else begin
      rpm_set_q <= rpm_set_d;
    end
  end

  assign rpm_set = rpm_set_q;

endmodule

// File: tb/tb_rpm_control.sv
// Scoreboard bench for rpm_control: default-range and RPM_MAX=8000 instances share inputs.
module tb_rpm_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dir_rpm = 16'd1234;
  logic [15:0] alt_rpm = 16'd0;
  logic [15:0] rpm_set;
  logic [15:0] rpm_set_lim;

  int tests  = 0;
  int failed = 0;

  int exp_q[$];
  int exp_lim_q[$];

  rpm_control #(.WIDTH(16)) dut (
    .clk(clk), .resetn(rst), .dir_rpm(dir_rpm), .alt_rpm(alt_rpm), .rpm_set(rpm_set)
  );

  rpm_control #(.WIDTH(16), .RPM_MAX(16'd8000)) dut_lim (
    .clk(clk), .resetn(rst), .dir_rpm(dir_rpm), .alt_rpm(alt_rpm), .rpm_set(rpm_set_lim)
  );

  always #5 clk = ~clk;

  function automatic int model(input int d, input int a, input int max_v);
    int r;
    r = d - a;
    if (r < 0) return 0;
    if (r > max_v) return max_v;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // d is 0..65535, a is the signed correction -32768..32767
  task automatic drive(input int d, input int a);
    @(negedge clk);
    dir_rpm = 16'(d);
    alt_rpm = 16'(a);
    exp_q.push_back(model(d, a, 65535));
    exp_lim_q.push_back(model(d, a, 8000));
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      check("rpm_set", int'(rpm_set), exp_q.pop_front());
      check("rpm_set_lim", int'(rpm_set_lim), exp_lim_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int d;
    int a;
    #1;
    check("reset_initial", int'(rpm_set), 0);
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", int'(rpm_set), 0);
      check("reset_hold_lim", int'(rpm_set_lim), 0);
    end
    rst = 1'b0;
    @(posedge clk);
    #2;
    check("reset_release", int'(rpm_set), 1234);

    for (int i = 0; i <= 16; i++) drive(3000 + i, -i);

    drive(3000, 250);
    drive(100, 100);
    drive(10, 11);
    drive(0, 32767);
    drive(65535, -1);
    drive(65000, -32768);
    drive(65535, 0);
    drive(65535, -32768);
    drive(7990, -20);
    drive(8000, 0);
    drive(8001, 0);
    drive(7999, 0);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: begin d = $urandom_range(0, 65535); a = $urandom_range(0, 65535) - 32768; end
        1: begin d = $urandom_range(65400, 65535); a = -$urandom_range(0, 300); end
        2: begin d = $urandom_range(0, 300); a = $urandom_range(0, 300); end
        default: begin d = $urandom_range(7800, 8200); a = $urandom_range(0, 400) - 200; end
      endcase
      drive(d, a);
    end

    drive(3000, -5);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrun_reset", int'(rpm_set), 0);
    #2;
    rst = 1'b0;
    #1;
    check("midrun_reset_hold", int'(rpm_set), 0);
    @(posedge clk);
    #2;
    check("midrun_restore", int'(rpm_set), 3005);
    check("midrun_restore_lim", int'(rpm_set_lim), 3005);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rpm_control.md
# rpm_control

Motor speed setpoint combiner for the drone flight controller. Each clock it combines the unsigned directional RPM demand with the signed altitude correction, clamps the result to the legal motor range, and registers it as the motor RPM setpoint. It sits between the direction/altitude control loops and the motor PWM generator.

## Interface

**Parameters**
- `WIDTH`, 16: bit width of all RPM buses.
- `RPM_MAX`, 2^WIDTH-1 (65535): upper clamp for `rpm_set`. Must be ≤ 2^WIDTH-1.

**Ports**
- `clk` input 1: single clock; all state updates on the rising edge.
- `resetn` input 1: reset, asynchronous, active-high; the name is kept for codebase consistency.
- `dir_rpm` input WIDTH: directional RPM demand, unsigned.
- `alt_rpm` input WIDTH: altitude correction, two's-complement signed. Negative values raise RPM.
- `rpm_set` output WIDTH: registered, clamped motor RPM setpoint, unsigned.

## Operation

- **Combine:** raw = `dir_rpm` − `alt_rpm`.
  - `dir_rpm` is zero-extended and `alt_rpm` is sign-extended to WIDTH+2 bits, then subtracted signed. No intermediate overflow is possible.
- **Clamp:**
  - raw < 0 gives 0.
  - raw > `RPM_MAX` gives `RPM_MAX`.
  - Otherwise the result is raw truncated to WIDTH bits.
- **Register:** the clamped value is loaded into the `rpm_set` register every rising edge while reset is deasserted.
- **Protocol:** none. There is no enable or handshake, and inputs are sampled every cycle.
- **Arithmetic examples:**
  - `dir_rpm`=3000, `alt_rpm`=−5 (16'hFFFB) → 3005.
  - `dir_rpm`=3000, `alt_rpm`=+5 → 2995.
- **State:** the `rpm_set` register is the only state. No FSM.

## Timing

- **Reset:**
  - While `resetn`=1, `rpm_set`=0 immediately (asynchronous), without waiting for a clock edge.
  - It stays 0 while `resetn` is held high. Input changes during reset are ignored.
- **Release:** on the first rising edge after `resetn` falls, `rpm_set` takes the clamped value of the inputs sampled at that edge.
- **Latency:** 1 cycle. Inputs stable before rising edge N appear on `rpm_set` just after edge N and hold until edge N+1.
- **Reset mid-operation:** `rpm_set` clears to 0 asynchronously and the previous value is lost. Normal updates resume on the first edge after deassertion.
- **Clamp boundaries:**
  - raw = 0 → 0.
  - raw = `RPM_MAX` → `RPM_MAX`.
  - raw = `RPM_MAX`+1 → `RPM_MAX`.
  - raw = −1 → 0.
  - Maximum raw is 2^WIDTH−1 + 2^(WIDTH−1) and minimum raw is −(2^(WIDTH−1)−1); both must clamp correctly.
- **Output glitches:** none. `rpm_set` changes only on a rising edge or on reset assertion.

## Test plan

1. **Reset:** assert `resetn`=1 with `dir_rpm`=1234 and `alt_rpm`=0 while clocking → `rpm_set`=0 throughout. Deassert → `rpm_set`=1234 after the next rising edge.
2. **Sweep:** `dir_rpm`=i for i in 3000..3016 and `alt_rpm`=−j for j in 0..16, one pair per cycle → `rpm_set`=i+j after each edge (e.g. i=3016, j=16 → 3032).
3. **Positive correction:** `dir_rpm`=3000, `alt_rpm`=250 → 2750. Then `dir_rpm`=100, `alt_rpm`=100 → 0.
4. **Underflow clamp:** `dir_rpm`=10, `alt_rpm`=11 → 0. Then `dir_rpm`=0, `alt_rpm`=32767 → 0.
5. **Overflow clamp:** `dir_rpm`=65535, `alt_rpm`=−1 → 65535. Then `dir_rpm`=65000, `alt_rpm`=−32768 → 65535. With `RPM_MAX`=8000: `dir_rpm`=7990, `alt_rpm`=−20 → 8000.
6. **Mid-run reset:** with `rpm_set`=3005 established, pulse `resetn` high for 3 ns between edges → `rpm_set`=0 immediately. After deassertion, the next edge restores 3005.
